// File: rtl/quot_rem_recombine.sv
// quot_rem_recombine: rebuilds dividend x = quot*y + rem using a shift-add
// multiplier plus one remainder-add cycle; flags overflow, bad remainder, y==0.
`default_nettype none

module quot_rem_recombine #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] x,
  output logic             ovf,
  output logic             rem_err,
  output logic             div_zero,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW = 2 * WIDTH;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  quot_q;
  logic [WIDTH-1:0]  rem_q;
  logic [WIDTH-1:0]  y_q;
  logic [AW-1:0]     acc;
  logic [CW-1:0]     cnt;

  logic [AW-1:0]     y_shift;
  logic [AW:0]       sum;

  // One extra bit on the final add so a carry out of the product+rem is seen.
  always_comb begin
    y_shift = {{WIDTH{1'b0}}, y_q} << cnt;
    sum     = {1'b0, acc} + {{(WIDTH + 1){1'b0}}, rem_q};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      quot_q   <= '0;
      rem_q    <= '0;
      y_q      <= '0;
      acc      <= '0;
      cnt      <= '0;
      x        <= '0;
      ovf      <= 1'b0;
      rem_err  <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            quot_q <= quot;
            rem_q  <= rem;
            y_q    <= y;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= MUL;
          end
        end
        MUL: begin
          if (quot_q[cnt]) begin
            acc <= acc + y_shift;
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= ADD;
          end
        end
        ADD: begin
          x        <= sum[WIDTH-1:0];
          ovf      <= |sum[AW:WIDTH];
          div_zero <= (y_q == '0);
          rem_err  <= (y_q != '0) && (rem_q >= y_q);
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_quot_rem_recombine.sv
// Scoreboard bench for quot_rem_recombine: directed cases plus random ops
// checked against a plain-arithmetic reference model.
`default_nettype none

module tb_quot_rem_recombine;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] quot = '0;
  logic [W-1:0] rem = '0;
  logic [W-1:0] y = '0;
  logic [W-1:0] x;
  logic         ovf, rem_err, div_zero, busy, done;

  quot_rem_recombine #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .quot(quot), .rem(rem), .y(y),
    .x(x), .ovf(ovf), .rem_err(rem_err), .div_zero(div_zero),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] x;
    logic         ovf;
    logic         rem_err;
    logic         div_zero;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   busy_cnt = 0;
  int   lat;

  function automatic exp_t model(input logic [W-1:0] q, input logic [W-1:0] r, input logic [W-1:0] d);
    logic [63:0] full;
    exp_t e;
    full       = 64'(q) * 64'(d) + 64'(r);
    e.x        = full[W-1:0];
    e.ovf      = (full >= (64'd1 << W));
    e.div_zero = (d == 0);
    e.rem_err  = (d != 0) && (r >= d);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("x", 32'(x), 32'(mon_e.x));
        check("ovf", 32'(ovf), 32'(mon_e.ovf));
        check("rem_err", 32'(rem_err), 32'(mon_e.rem_err));
        check("div_zero", 32'(div_zero), 32'(mon_e.div_zero));
      end
    end
  end

  always @(negedge clk) begin
    if (busy) busy_cnt++;
  end

  task automatic issue(input logic [W-1:0] q, input logic [W-1:0] r, input logic [W-1:0] d);
    @(negedge clk);
    quot  = q;
    rem   = r;
    y     = d;
    start = 1'b1;
    @(posedge clk);
    sb.push_back(model(q, r, d));
    @(negedge clk);
    start = 1'b0;
    quot  = W'($urandom);
    rem   = W'($urandom);
    y     = W'($urandom);
  endtask

  // Returns number of negedges since the accepting edge when done is seen.
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    logic [W-1:0] q, r, d;

    repeat (3) @(negedge clk);
    check("rst_x", 32'(x), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_rem_err", 32'(rem_err), 32'd0);
    check("rst_div_zero", 32'(div_zero), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;

    busy_cnt = 0;
    issue(16'd3, 16'd0, 16'd2);
    wait_done(lat);
    check("latency", 32'(lat), 32'(W + 2));
    check("busy_cycles", 32'(busy_cnt), 32'(W + 1));

    issue(16'd5, 16'd3, 16'd4);
    wait_done(lat);
    issue(16'd3, 16'd0, 16'd4);
    wait_done(lat);
    repeat (3) @(negedge clk);
    check("x_hold", 32'(x), 32'd12);

    issue(16'd2, 16'd5, 16'd4);      wait_done(lat);
    issue(16'hFFFF, 16'd0, 16'd2);   wait_done(lat);
    issue(16'hFFFF, 16'd1, 16'd1);   wait_done(lat);
    issue(16'd7, 16'd9, 16'd0);      wait_done(lat);

    // start re-asserted with new operands mid-multiply must be ignored
    issue(16'd100, 16'd7, 16'd300);
    repeat (4) @(negedge clk);
    quot  = 16'hABCD;
    rem   = 16'h1111;
    y     = 16'h0033;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    repeat (W + 6) @(negedge clk);

    // asynchronous reset mid-multiply
    issue(16'h1234, 16'd5, 16'h0077);
    repeat (7) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    sb.delete();
    check("mid_rst_x", 32'(x), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_div_zero", 32'(div_zero), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (W + 4) @(negedge clk);
    issue(16'd3, 16'd0, 16'd2);
    wait_done(lat);

    repeat (40) begin
      q = W'($urandom);
      case ($urandom_range(0, 3))
        0:       d = '0;
        1:       d = W'($urandom_range(1, 20));
        default: d = W'($urandom);
      endcase
      if ($urandom_range(0, 1) == 0 && d != 0) r = W'($urandom % d);
      else                                     r = W'($urandom);
      issue(q, r, d);
      wait_done(lat);
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
